// File: rtl/bus_initiator_pkg.sv
// rtl/bus_initiator_pkg.sv - shared CPU bus types and constants
package bus_initiator_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int ctr_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - access-phase wait counter with expiry flag
// expire is high during the last permitted ACCESS cycle, so a missing ack then ends the access.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  import bus_initiator_pkg::*;

  localparam int CW = ctr_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          count <= '0;
        end else if (inc) begin
          count <= count + 1'b1;
        end
      end

      assign expire = (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - strobe-bus initiator: setup, access with ack/timeout, one-cycle response
module bus_initiator #(
  parameter int DATA_W  = bus_initiator_pkg::DATA_W,
  parameter int ADDR_W  = bus_initiator_pkg::ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);
  import bus_initiator_pkg::*;

  state_t state, state_next;
  logic   we_q;
  logic   accept;
  logic   ctr_clear, ctr_inc, ctr_expire;
  logic   req_ready_d, resp_valid_d, resp_err_d, bus_read_d, bus_write_d;

  assign accept    = (state == IDLE) && req_valid;
  assign ctr_clear = (state == SETUP);
  assign ctr_inc   = (state == ACCESS) && !bus_ack;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .inc    (ctr_inc),
    .expire (ctr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus_ack || ctr_expire) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so each output lines up with its state.
  always_comb begin
    req_ready_d  = (state_next == IDLE);
    resp_valid_d = (state_next == RESP);
    resp_err_d   = (state == ACCESS) && (state_next == RESP) && !bus_ack;
    bus_read_d   = (state_next == ACCESS) && !we_q;
    bus_write_d  = (state_next == ACCESS) && we_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      bus_read   <= bus_read_d;
      bus_write  <= bus_write_d;
      if (accept) begin
        bus_addr  <= req_addr;
        bus_wdata <= req_wdata;
        we_q      <= req_we;
      end
      if (state == ACCESS && !we_q) begin
        if (bus_ack) begin
          resp_rdata <= bus_rdata;
        end else if (ctr_expire) begin
          resp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - self-checking bench for bus_initiator
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        bus_read, bus_write, bus_ack;

  int n_checks = 0;
  int n_errors = 0;
  int n_resp   = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_e;

  typedef struct {
    logic        we;
    logic        spur;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    int          ack_at;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_strobe;
  } txn_t;

  txn_t tbl[6];

  bus_initiator #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
      end else begin
        exp_e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_e[32]});
        chk("resp_rdata", resp_rdata, exp_e[31:0]);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_txn(input txn_t t, input string name);
    int  cycles = 0;
    logic strobe, other;
    wait_ready({name, "_ready"});
    req_valid = 1'b1;
    req_we    = t.we;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    bus_ack   = t.spur;
    bus_rdata = t.bus_rd;
    sb.push_back({t.exp_err, t.exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~t.addr;
    req_wdata = ~t.wdata;
    chk({name, "_setup_strobe"}, {30'd0, bus_read, bus_write}, 32'd0);
    chk({name, "_setup_ready"}, {31'd0, req_ready}, 32'd0);
    chk({name, "_setup_addr"}, bus_addr, t.addr);
    chk({name, "_setup_wdata"}, bus_wdata, t.wdata);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      strobe = t.we ? bus_write : bus_read;
      other  = t.we ? bus_read : bus_write;
      if (!strobe) break;
      cycles++;
      chk({name, "_other_strobe"}, {31'd0, other}, 32'd0);
      chk({name, "_access_addr"}, bus_addr, t.addr);
      chk({name, "_access_wdata"}, bus_wdata, t.wdata);
      bus_ack = (cycles == t.ack_at);
    end
    bus_ack = 1'b0;
    chk({name, "_strobe_cycles"}, cycles, t.exp_strobe);
    chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({name, "_resp_ready"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk({name, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
    chk({name, "_err_drop"}, {31'd0, resp_err}, 32'd0);
    chk({name, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, n_acc;
    //            we    spur  addr          wdata         bus_rd        ack exp_err exp_rdata     strobe
    tbl[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 1};
    tbl[1] = '{1'b1, 1'b0, 32'h1000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 5, 1'b0, 32'hDEAD_BEEF, 5};
    tbl[2] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 15};
    tbl[3] = '{1'b0, 1'b0, 32'h2000_0004, 32'h0000_0000, 32'hCAFE_F00D, 15, 1'b0, 32'hCAFE_F00D, 15};
    tbl[4] = '{1'b1, 1'b0, 32'h2000_0008, 32'hA5A5_5A5A, 32'h1111_1111, 0, 1'b1, 32'hCAFE_F00D, 15};
    tbl[5] = '{1'b0, 1'b1, 32'h2000_000C, 32'h0000_0000, 32'h0BAD_C0DE, 2, 1'b0, 32'h0BAD_C0DE, 2};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = 32'h7777_7777;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset during ACCESS of a write aborts it without a response.
    wait_ready("abort_ready");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3000_0000; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_strobe_on", {31'd0, bus_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobe_off", {30'd0, bus_read, bus_write}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_addr", bus_addr, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_txn('{1'b0, 1'b0, 32'h3000_0004, 32'h0, 32'h1357_9BDF, 3, 1'b0, 32'h1357_9BDF, 3}, "post_abort");

    // Back-to-back reads, req_valid held, ack held high through IDLE and SETUP.
    acc1 = -1; acc2 = -1; n_acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0000;
    bus_ack = 1'b1; bus_rdata = 32'h0101_0101;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (req_valid && req_ready) begin
        n_acc++;
        if (n_acc == 1) begin
          acc1 = k;
          sb.push_back({1'b0, 32'h0101_0101});
        end else begin
          acc2 = k;
          sb.push_back({1'b0, 32'h0202_0202});
        end
      end
      if (acc2 >= 0 && k == acc2 + 1) chk("b2b_addr2", bus_addr, 32'h4000_0010);
      if (n_acc == 1 && k > acc1) req_addr = 32'h4000_0010;
      if (n_acc >= 2 && k > acc2) req_valid = 1'b0;
      bus_rdata = (n_acc >= 2) ? 32'h0202_0202 : 32'h0101_0101;
    end
    bus_ack = 1'b0;
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 32'd2);
    chk("b2b_spacing", acc2 - acc1, 32'd4);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("resp_count", n_resp, 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Initiator (master) side of the CPU's internal register/memory strobe bus.
- Register-type responders sit on that bus. They take an address, write data and Read/Write strobes, and return read data.
- This block accepts single-word read/write requests from the multicycle control unit and sequences the address-setup and strobe phases.
- It waits for the responder's acknowledge, applies a timeout, and returns a one-cycle response carrying the read data or an error flag.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- TIMEOUT, 15, maximum ACCESS cycles without bus_ack before an error response. 0 disables the timeout and waits indefinitely.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_err  out  1  qualifies resp_valid; 1 = timeout.
- resp_rdata  out  DATA_W  read result.
- bus_addr  out  ADDR_W  address to responders.
- bus_wdata  out  DATA_W  write data to responders.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_rdata  in  DATA_W  read data from the selected responder.
- bus_ack  in  1  responder has completed the access.

Behaviour:
- Reset: rst is synchronous, active-high. At the next rising edge with rst=1:
  - state goes to IDLE;
  - req_ready=1, resp_valid=0, resp_err=0;
  - bus_read=0, bus_write=0;
  - bus_addr=0, bus_wdata=0, resp_rdata=0;
  - timeout counter=0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch req_addr and req_wdata into bus_addr and bus_wdata, latch req_we, then go to SETUP.
  - req_valid=0: stay in IDLE.
- SETUP (exactly 1 cycle):
  - Address and data are stable; bus_read=bus_write=0; req_ready=0.
  - Next state: ACCESS. The matching strobe (bus_write if we=1, else bus_read) rises on entry to ACCESS.
- ACCESS:
  - Exactly one strobe is high; address and data are held constant.
  - On bus_ack=1: drop the strobe at the next edge. For a read, capture bus_rdata into resp_rdata on that same edge. Set resp_err=0, go to RESP.
  - Otherwise the counter increments each cycle.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: drop the strobe, set resp_err=1, go to RESP. For a read, resp_rdata is set to 0.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE; resp_valid and resp_err return to 0.
  - There is no response backpressure.
- resp_rdata holds its value until the next completed read. Writes never change it.
- Latency: request accepted at edge T; strobe asserted during cycle T+1..; ack sampled at edge T+2 gives resp_valid high during T+3. A new request can be accepted at edge T+4 or later.
- Timeout boundary: with TIMEOUT=N, an ack in the N-th ACCESS cycle completes normally. Only a missing ack at that cycle gives an error.
- Ignored inputs:
  - bus_ack outside ACCESS is ignored.
  - req_valid outside IDLE is ignored; the requester must hold it until it sees req_ready.
- Reset mid-operation: at the reset edge the strobe deasserts and state returns to IDLE. No resp_valid is produced for the aborted request.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit. It clears on every entry to ACCESS.

Decomposition:
- Shared CPU package holds:
  - state encoding enum: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - bus width constants DATA_W and ADDR_W;
  - the reset address constant used by the PC responder (32'h0040_0000).
- One sub-module is natural: bus_timeout_ctr. It is a loadable clear/increment counter with a terminal-count flag at TIMEOUT and is disabled when TIMEOUT=0.

Test Plan:
- Reset, then idle: req_ready=1, bus_read=bus_write=0, resp_valid=0, resp_rdata=0.
- Read, addr=0x0040_0000, responder acks in first ACCESS cycle with 0xDEAD_BEEF: bus_read high exactly 1 cycle; resp_valid 3 cycles after accept; resp_rdata=0xDEAD_BEEF; resp_err=0.
- Write, addr=0x1000_0010, data=0x1234_5678, ack after 4 wait cycles: bus_write high 5 cycles with stable addr/data; single resp_valid; resp_rdata unchanged from the previous read.
- Read with ack never asserted, TIMEOUT=15: bus_read drops after 15 ACCESS cycles; resp_valid=1 with resp_err=1; resp_rdata=0.
- rst pulsed during ACCESS of a write: strobe low at the reset edge; no resp_valid; next request completes normally.
- Back-to-back reads with req_valid held high: second accept no earlier than 4 cycles after the first; spurious bus_ack pulses in IDLE and SETUP have no effect.
